gshare_branch_predictor: RTL and testbench

- Parametrised successor to the fixed PC+4 predictor in the 5-stage RV32I pipeline. It sits in IF and supplies the next-PC prediction to the miss mux.
- Contains a direct-mapped BTB (tag, target, valid), a pattern history table of 2-bit saturating counters, and a non-speculative global history register (GHR).
- Runtime mode selects static not-taken, bimodal or gshare indexing.
- The EX stage trains the block on resolution using the lookup index carried down the pipeline.

---
 rtl/bp_pkg.sv | 23 ++
 rtl/sat_counter_table.sv | 37 +++
 rtl/gshare_branch_predictor.sv | 160 ++++++++++++++++
 tb/tb_gshare_branch_predictor.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor slice.
//   - Mode encodings for the runtime predictor selection.
//   - 2-bit saturating counter states and the update helper sat2().
package bp_pkg;

    localparam logic [1:0] BP_STATIC  = 2'd0;
    localparam logic [1:0] BP_BIMODAL = 2'd1;
    localparam logic [1:0] BP_GSHARE  = 2'd2;

    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    // Next state of a 2-bit saturating counter after one resolved outcome.
    function automatic logic [1:0] sat2(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Pattern history table: ENTRIES x 2-bit saturating counters.
//   clk, reset : clock, asynchronous active-low reset (all counters -> weakly not-taken)
//   rd_idx     : combinational read index
//   rd_cnt     : counter at rd_idx (pre-update value when written in the same cycle)
//   wr_en      : apply one training outcome at the next rising edge
//   wr_idx     : counter to train
//   wr_taken   : resolved direction (increment on 1, decrement on 0, saturating)
module sat_counter_table
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES  = 32,
    parameter int unsigned IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [1:0]          rd_cnt,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    logic [1:0] cnt_q [ENTRIES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= CNT_WNT;
            end
        end else if (wr_en) begin
            cnt_q[wr_idx] <= sat2(cnt_q[wr_idx], wr_taken);
        end
    end

    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/gshare_branch_predictor.sv
// IF-stage next-PC predictor: direct-mapped BTB + 2-bit PHT + non-speculative GHR.
//   clk, reset      : clock, asynchronous active-low reset
//   mode            : 0 static not-taken, 1 bimodal, 2 gshare, 3 behaves as 0
//   current_pc      : IF-stage PC to look up
//   pred_pc         : predicted next PC (BTB target if predicted taken, else PC+4)
//   pred_taken      : lookup predicts taken
//   pred_idx        : PHT index used by this lookup, carried down the pipe to EX
//   upd_*           : EX-stage resolution (valid, is_cond, pc, idx, taken, target, miss)
//   ghr_out         : current global history
//   n_updates       : saturating count of resolved control transfers
//   n_misses        : saturating count of mispredictions
module gshare_branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 32,
    parameter int unsigned IDX_BITS    = $clog2(BTB_ENTRIES),
    parameter int unsigned GHR_BITS    = 5,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic [XLEN-1:0]     current_pc,
    output logic [XLEN-1:0]     pred_pc,
    output logic                pred_taken,
    output logic [IDX_BITS-1:0] pred_idx,
    input  logic                upd_valid,
    input  logic                upd_is_cond,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic [IDX_BITS-1:0] upd_idx,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target,
    input  logic                upd_miss,
    output logic [GHR_BITS-1:0] ghr_out,
    output logic [CNT_W-1:0]    n_updates,
    output logic [CNT_W-1:0]    n_misses
);

    localparam int unsigned TAG_W = XLEN - IDX_BITS - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
    logic [GHR_BITS-1:0]    ghr_q;
    logic [CNT_W-1:0]       n_updates_q;
    logic [CNT_W-1:0]       n_misses_q;

    logic [IDX_BITS-1:0] bidx;
    logic [TAG_W-1:0]    tag;
    logic [IDX_BITS-1:0] upd_bidx;
    logic [TAG_W-1:0]    upd_tag;
    logic                hit;
    logic                dyn_mode;
    logic [1:0]          pht_cnt;

    // Word-offset bits of the PCs carry no information for the tables.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{current_pc[1:0], upd_pc[1:0]};

    assign bidx     = current_pc[IDX_BITS+1:2];
    assign tag      = current_pc[XLEN-1:IDX_BITS+2];
    assign upd_bidx = upd_pc[IDX_BITS+1:2];
    assign upd_tag  = upd_pc[XLEN-1:IDX_BITS+2];

    // ---------------------------------------------------------------- lookup
    always_comb begin
        pred_idx = '0;
        dyn_mode = 1'b0;
        case (mode)
            BP_BIMODAL: begin
                pred_idx = bidx;
                dyn_mode = 1'b1;
            end
            BP_GSHARE: begin
                pred_idx = bidx ^ IDX_BITS'(ghr_q);
                dyn_mode = 1'b1;
            end
            default: begin
                pred_idx = '0;
                dyn_mode = 1'b0;
            end
        endcase
    end

    assign hit        = valid_q[bidx] && (tag_q[bidx] == tag);
    assign pred_taken = dyn_mode && hit && pht_cnt[1];
    assign pred_pc    = pred_taken ? tgt_q[bidx] : current_pc + XLEN'(4);

    // Trained in every mode so a later mode switch starts from warm counters.
    sat_counter_table #(
        .ENTRIES  (BTB_ENTRIES),
        .IDX_BITS (IDX_BITS)
    ) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (pred_idx),
        .rd_cnt   (pht_cnt),
        .wr_en    (upd_valid),
        .wr_idx   (upd_idx),
        .wr_taken (upd_taken)
    );

    // ------------------------------------------------------------------- BTB
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else if (upd_valid && upd_taken) begin
            valid_q[upd_bidx] <= 1'b1;
            tag_q[upd_bidx]   <= upd_tag;
            tgt_q[upd_bidx]   <= upd_target;
        end
    end

    // ------------------------------------------------------------------- GHR
    // Only conditional branches shift history; jal/jalr would just dilute it.
    generate
        if (GHR_BITS == 1) begin : g_ghr_one
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ghr_q <= '0;
                end else if (upd_valid && upd_is_cond) begin
                    ghr_q <= upd_taken;
                end
            end
        end else begin : g_ghr_shift
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ghr_q <= '0;
                end else if (upd_valid && upd_is_cond) begin
                    ghr_q <= {ghr_q[GHR_BITS-2:0], upd_taken};
                end
            end
        end
    endgenerate

    // ------------------------------------------------- performance counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_updates_q <= '0;
            n_misses_q  <= '0;
        end else if (upd_valid) begin
            if (n_updates_q != '1) begin
                n_updates_q <= n_updates_q + CNT_W'(1);
            end
            if (upd_miss && (n_misses_q != '1)) begin
                n_misses_q <= n_misses_q + CNT_W'(1);
            end
        end
    end

    assign ghr_out   = ghr_q;
    assign n_updates = n_updates_q;
    assign n_misses  = n_misses_q;

endmodule

// File: tb/tb_gshare_branch_predictor.sv
module tb_gshare_branch_predictor;

    localparam int ENT  = 32;
    localparam int IDXB = 5;
    localparam int GHRB = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic [31:0] current_pc;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [4:0]  pred_idx;
    logic        upd_valid;
    logic        upd_is_cond;
    logic [31:0] upd_pc;
    logic [4:0]  upd_idx;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_miss;
    logic [4:0]  ghr_out;
    logic [31:0] n_updates;
    logic [31:0] n_misses;

    always #5 clk = ~clk;

    gshare_branch_predictor #(
        .XLEN        (32),
        .BTB_ENTRIES (ENT),
        .GHR_BITS    (GHRB),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .current_pc  (current_pc),
        .pred_pc     (pred_pc),
        .pred_taken  (pred_taken),
        .pred_idx    (pred_idx),
        .upd_valid   (upd_valid),
        .upd_is_cond (upd_is_cond),
        .upd_pc      (upd_pc),
        .upd_idx     (upd_idx),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_miss    (upd_miss),
        .ghr_out     (ghr_out),
        .n_updates   (n_updates),
        .n_misses    (n_misses)
    );

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] idx;
        logic [31:0] ghr;
        logic [31:0] nupd;
        logic [31:0] nmiss;
    } want_t;

    want_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model: tables indexed by word address, history as an integer.
    bit          m_valid [ENT];
    logic [31:0] m_pc    [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_pht   [ENT];
    int          m_ghr;
    logic [31:0] m_nupd;
    logic [31:0] m_nmiss;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int ent(input logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0;
            m_pc[i]    = '0;
            m_tgt[i]   = '0;
            m_pht[i]   = 1;
        end
        m_ghr   = 0;
        m_nupd  = '0;
        m_nmiss = '0;
    endtask

    task automatic model_predict(input logic [1:0] md, input logic [31:0] pc, output want_t w);
        int  e;
        int  idx;
        bit  hit;
        e = ent(pc);
        if (md == 2'd1) idx = e;
        else if (md == 2'd2) idx = e ^ m_ghr;
        else idx = 0;
        hit     = m_valid[e] && ((m_pc[e] / 128) == (pc / 128));
        w.taken = (md == 2'd1 || md == 2'd2) && hit && (m_pht[idx] >= 2);
        w.pc    = w.taken ? m_tgt[e] : pc + 32'd4;
        w.idx   = idx;
        w.ghr   = m_ghr;
        w.nupd  = m_nupd;
        w.nmiss = m_nmiss;
    endtask

    task automatic model_update(input bit cond, input logic [31:0] pc, input int idx,
                                input bit tk, input logic [31:0] tgt, input bit miss);
        if (tk) begin
            m_valid[ent(pc)] = 1;
            m_pc[ent(pc)]    = pc;
            m_tgt[ent(pc)]   = tgt;
        end
        if (tk) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
        else    m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
        if (cond) m_ghr = ((m_ghr * 2) + int'(tk)) % (1 << GHRB);
        if (m_nupd != 32'hFFFF_FFFF) m_nupd = m_nupd + 1;
        if (miss && m_nmiss != 32'hFFFF_FFFF) m_nmiss = m_nmiss + 1;
    endtask

    // One cycle of stimulus; expectation is queued from the pre-update model state.
    task automatic step(input logic [1:0] md, input logic [31:0] cur, input bit uv,
                        input bit cond, input logic [31:0] upc, input int uidx, input bit tk,
                        input logic [31:0] tgt, input bit miss);
        want_t w;
        @(posedge clk);
        #1;
        mode        = md;
        current_pc  = cur;
        upd_valid   = uv;
        upd_is_cond = cond;
        upd_pc      = upc;
        upd_idx     = uidx[4:0];
        upd_taken   = tk;
        upd_target  = tgt;
        upd_miss    = miss;
        model_predict(md, cur, w);
        sb.push_back(w);
        if (uv) model_update(cond, upc, uidx, tk, tgt, miss);
        #1;
    endtask

    task automatic upd(input logic [1:0] md, input bit cond, input logic [31:0] upc,
                       input int uidx, input bit tk, input logic [31:0] tgt);
        step(md, 32'h40, 1, cond, upc, uidx, tk, tgt, tk);
    endtask

    // Lookup only; upd_* carry junk that must be ignored.
    task automatic look(input logic [1:0] md, input logic [31:0] cur);
        step(md, cur, 0, 1, $urandom, int'($urandom_range(0, 31)), 1, $urandom, 1);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        if ($urandom_range(0, 9) == 0) p = $urandom & 32'hFFFF_FFFC;
        else p = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 31)) << 2);
        return p;
    endfunction

    task automatic rand_steps(input int n);
        logic [31:0] upc;
        int          uidx;
        for (int i = 0; i < n; i++) begin
            upc  = rand_pc();
            uidx = ($urandom_range(0, 1) == 1) ? ent(upc) ^ m_ghr : int'($urandom_range(0, 31));
            step(2'($urandom_range(0, 3)), rand_pc(), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), upc, uidx, bit'($urandom_range(0, 1)),
                 $urandom & 32'hFFFF_FFFC, bit'($urandom_range(0, 1)));
        end
    endtask

    // Scoreboard monitor: pops every queued expectation mid-cycle.
    initial begin
        want_t w;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                w = sb.pop_front();
                chk("sb_pred_pc", pred_pc, w.pc);
                chk("sb_pred_taken", 32'(pred_taken), 32'(w.taken));
                chk("sb_pred_idx", 32'(pred_idx), w.idx);
                chk("sb_ghr", 32'(ghr_out), w.ghr);
                chk("sb_n_updates", n_updates, w.nupd);
                chk("sb_n_misses", n_misses, w.nmiss);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; mode = 2'd0; current_pc = 32'h40;
        upd_valid = 1'b0; upd_is_cond = 1'b0; upd_pc = '0; upd_idx = '0;
        upd_taken = 1'b0; upd_target = '0; upd_miss = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;

        // Reset state
        look(2'd0, 32'h40);
        chk("rst_pred_pc", pred_pc, 32'h44);
        chk("rst_taken", 32'(pred_taken), 32'd0);
        chk("rst_ghr", 32'(ghr_out), 32'd0);
        chk("rst_nupd", n_updates, 32'd0);
        chk("rst_nmiss", n_misses, 32'd0);
        look(2'd1, 32'h40);
        look(2'd2, 32'h40);

        // Bimodal training
        upd(2'd1, 1, 32'h100, 0, 1, 32'h80);
        upd(2'd1, 1, 32'h100, 0, 1, 32'h80);
        look(2'd1, 32'h100);
        chk("bim_taken", 32'(pred_taken), 32'd1);
        chk("bim_pc", pred_pc, 32'h80);
        upd(2'd1, 1, 32'h100, 0, 0, 32'h0);
        upd(2'd1, 1, 32'h100, 0, 0, 32'h0);
        look(2'd1, 32'h100);
        chk("bim_untrained_pc", pred_pc, 32'h104);

        // Gshare: history N,N,T,N,T -> 00101
        upd(2'd2, 1, 32'h1F0, 31, 0, 32'h0);
        upd(2'd2, 1, 32'h1F0, 31, 0, 32'h0);
        upd(2'd2, 1, 32'h1F0, 31, 1, 32'h600);
        upd(2'd2, 1, 32'h1F0, 31, 0, 32'h0);
        upd(2'd2, 1, 32'h1F0, 31, 1, 32'h600);
        look(2'd2, 32'h100);
        chk("gs_ghr", 32'(ghr_out), 32'h5);
        chk("gs_idx", 32'(pred_idx), 32'd5);
        chk("gs_pc_cold", pred_pc, 32'h104);
        upd(2'd2, 0, 32'h100, 5, 1, 32'h80);
        upd(2'd2, 0, 32'h100, 5, 1, 32'h80);
        look(2'd2, 32'h100);
        chk("gs_pc_trained", pred_pc, 32'h80);
        look(2'd1, 32'h100);
        chk("gs_bim_unchanged", pred_pc, 32'h104);

        // Saturation; jal-style updates leave history alone
        repeat (5) upd(2'd1, 0, 32'h10C, 3, 1, 32'h400);
        look(2'd1, 32'h10C);
        chk("sat_ghr_kept", 32'(ghr_out), 32'h5);
        chk("sat_pc", pred_pc, 32'h400);
        upd(2'd1, 1, 32'h10C, 3, 0, 32'h0);
        look(2'd1, 32'h10C);
        chk("sat_still_taken", 32'(pred_taken), 32'd1);

        // Same-cycle lookup and update to the same entry: read-old
        upd(2'd1, 0, 32'h100, 0, 1, 32'h80);
        upd(2'd1, 0, 32'h100, 0, 1, 32'h80);
        step(2'd1, 32'h200, 1, 0, 32'h200, 0, 1, 32'h300, 0);
        chk("coll_old", pred_pc, 32'h204);
        look(2'd1, 32'h200);
        chk("coll_new", pred_pc, 32'h300);

        rand_steps(400);

        // Asynchronous reset between edges with live entries
        upd(2'd1, 0, 32'h100, 0, 1, 32'h80);
        upd(2'd1, 0, 32'h100, 0, 1, 32'h80);
        look(2'd1, 32'h100);
        chk("pre_rst_pc", pred_pc, 32'h80);
        @(posedge clk);
        #1;
        mode = 2'd1; current_pc = 32'h100;
        upd_valid = 1'b1; upd_is_cond = 1'b1; upd_pc = 32'h100; upd_idx = 5'd0;
        upd_taken = 1'b1; upd_target = 32'h80; upd_miss = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("arst_pc", pred_pc, 32'h104);
        chk("arst_taken", 32'(pred_taken), 32'd0);
        chk("arst_nmiss", n_misses, 32'd0);
        chk("arst_nupd", n_updates, 32'd0);
        chk("arst_ghr", 32'(ghr_out), 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        chk("arst_dropped_upd", n_updates, 32'd0);
        #4;
        reset = 1'b1;
        upd_valid = 1'b0;
        look(2'd1, 32'h100);
        chk("post_rst_miss", pred_pc, 32'h104);
        rand_steps(60);

        @(posedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
